// File: rtl/debounce_sync_pkg.sv
// ---------------------------------------------------------------------------
// debounce_sync_pkg
//   Shared definitions for the debounce_sync input conditioner.
//   - state_t     : debounce FSM state encoding (STABLE / COUNT)
//   - SYNC_MIN    : smallest synchroniser depth that is safe against metastability
// ---------------------------------------------------------------------------
package debounce_sync_pkg;

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_COUNT  = 1'b1
    } state_t;

    localparam int SYNC_MIN = 2;

endpackage

// File: rtl/debounce_sync_sync_chain.sv
// ---------------------------------------------------------------------------
// sync_chain
//   Plain flop-chain synchroniser for a single asynchronous level. Reused by
//   other CDC inputs in the block library, so it carries no debounce logic.
// Ports
//   clk  in  1  destination clock, posedge
//   rst  in  1  asynchronous reset, active-low; all stages load RST_VAL
//   d    in  1  asynchronous input level
//   q    out 1  synchronised level (last stage)
// ---------------------------------------------------------------------------
module sync_chain #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] stages;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stages <= {SYNC_STAGES{RST_VAL}};
        end else begin
            stages <= {stages[SYNC_STAGES-2:0], d};
        end
    end

    assign q = stages[SYNC_STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// ---------------------------------------------------------------------------
// debounce_sync
//   Input conditioner placed directly upstream of an enable-gated D flop.
//   Synchronises an asynchronous level, debounces it and presents a stable
//   level plus registered one-cycle rise/fall/chg strobes that are coincident
//   with the first cycle dout shows the new value.
// Ports
//   clk   in  1  system clock, posedge
//   rst   in  1  asynchronous reset, active-low
//   en    in  1  clock enable; low freezes everything but the synchroniser
//   din   in  1  asynchronous raw input
//   dout  out 1  debounced, synchronised level
//   rise  out 1  one-cycle pulse, dout went 0->1
//   fall  out 1  one-cycle pulse, dout went 1->0
//   chg   out 1  rise | fall, registered (downstream flop enable)
// Handshake: none; en is a plain qualifier sampled every posedge.
// ---------------------------------------------------------------------------
module debounce_sync
    import debounce_sync_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter int   CNT_W       = 16,
    parameter int   DEBOUNCE    = 1000,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall,
    output logic chg
);

    // Elaboration-time parameter legality.
    if (SYNC_STAGES < SYNC_MIN) begin : g_bad_sync
        $error("debounce_sync: SYNC_STAGES must be >= 2");
    end
    if ((DEBOUNCE < 1) || (longint'(DEBOUNCE) > ((longint'(1) << CNT_W) - 1))) begin : g_bad_deb
        $error("debounce_sync: DEBOUNCE must be in 1..2**CNT_W-1");
    end

    // Count value at which the next enabled mismatch cycle accepts the level.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

    logic             s;
    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             dout_nx, rise_nx, fall_nx;

    sync_chain #(
        .SYNC_STAGES (SYNC_STAGES),
        .RST_VAL     (RST_VAL)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (din),
        .q   (s)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_STABLE;
            cnt   <= '0;
            dout  <= RST_VAL;
            rise  <= 1'b0;
            fall  <= 1'b0;
            chg   <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            dout  <= dout_nx;
            rise  <= rise_nx;
            fall  <= fall_nx;
            chg   <= rise_nx | fall_nx;
        end
    end

    // Strobes default low every cycle, so they last exactly one cycle after
    // an accept and are automatically forced low while en is low.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        dout_nx  = dout;
        rise_nx  = 1'b0;
        fall_nx  = 1'b0;
        if (en) begin
            case (state)
                ST_STABLE: begin
                    if (s != dout) begin
                        if (DEBOUNCE == 1) begin
                            // One mismatch cycle is already enough.
                            dout_nx = s;
                            rise_nx = s;
                            fall_nx = ~s;
                        end else begin
                            state_nx = ST_COUNT;
                            cnt_nx   = CNT_W'(1);
                        end
                    end
                end
                ST_COUNT: begin
                    if (s == dout) begin
                        // Glitch shorter than the debounce window: drop it.
                        state_nx = ST_STABLE;
                        cnt_nx   = '0;
                    end else if (cnt == CNT_LAST) begin
                        state_nx = ST_STABLE;
                        cnt_nx   = '0;
                        dout_nx  = s;
                        rise_nx  = s;
                        fall_nx  = ~s;
                    end else begin
                        cnt_nx = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_nx = ST_STABLE;
                    cnt_nx   = '0;
                end
            endcase
        end
    end

endmodule
